// File: rtl/adder_arb_pkg.sv
// Shared types and the round-robin search helper for the adder arbiter and
// other shared-unit arbiters.
package adder_arb_pkg;

    localparam int ADD_W   = 64;
    localparam int MAX_REQ = 16;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Returns {found, index} of the first set bit of valid, searching cyclically from ptr.
    function automatic logic [4:0] rr_next(input logic [3:0]  ptr,
                                           input logic [15:0] valid,
                                           input logic [4:0]  nreq);
        logic [4:0] res;
        logic [4:0] idx;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = {1'b0, ptr} + 5'(k);
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            if ((5'(k) < nreq) && !res[4] && valid[idx[3:0]]) begin
                res = {1'b1, idx[3:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/adder_64.sv
// 64-bit carry-select adder: the upper half is precomputed for both carries
// and selected by the lower half's carry-out.
module adder_64
    import adder_arb_pkg::*;
(
    input  logic [ADD_W-1:0] in1,
    input  logic [ADD_W-1:0] in2,
    input  logic             cin,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);

    localparam int H = ADD_W / 2;

    logic [H:0] lo;
    logic [H:0] hi0;
    logic [H:0] hi1;

    always_comb begin
        lo   = {1'b0, in1[H-1:0]} + {1'b0, in2[H-1:0]} + {{H{1'b0}}, cin};
        hi0  = {1'b0, in1[ADD_W-1:H]} + {1'b0, in2[ADD_W-1:H]};
        hi1  = {1'b0, in1[ADD_W-1:H]} + {1'b0, in2[ADD_W-1:H]} + {{H{1'b0}}, 1'b1};
        sum  = {(lo[H] ? hi1[H-1:0] : hi0[H-1:0]), lo[H-1:0]};
        cout = lo[H] ? hi1[H] : hi0[H];
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant plus encoded index, with an
// optional mask that restricts the choice to a single requester.
module rr_pick
    import adder_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [ID_W-1:0] ptr,
    input  logic            mask_en,
    input  logic [ID_W-1:0] mask_id,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id
);

    logic [NREQ-1:0] eff;
    logic [4:0]      pick;

    always_comb begin
        eff = valid;
        if (mask_en) begin
            eff = valid & (NREQ'(1) << mask_id);
        end
        pick     = rr_next(4'(ptr), 16'(eff), 5'(NREQ));
        grant_id = pick[ID_W-1:0];
        grant    = pick[4] ? (NREQ'(1) << pick[3:0]) : '0;
    end

endmodule

// File: rtl/adder_64_arbiter.sv
// Round-robin arbiter sharing one adder_64 among NREQ requesters, with a
// registered response channel. Define ADDER_ARB_LOCK_EN for multi-word locked adds.
module adder_64_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*64-1:0]       req_in1,
    input  logic [NREQ*64-1:0]       req_in2,
    input  logic [NREQ-1:0]          req_cin,
    input  logic [NREQ-1:0]          req_last,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [63:0]              rsp_sum,
    output logic                     rsp_cout,
    output logic [$clog2(NREQ)-1:0]  rsp_id
);

    localparam int ID_W = $clog2(NREQ);

    // Handshake: a beat moves when valid && ready; req_ready never depends on
    // req_valid of the same requester beyond the grant search, rsp holds while !rsp_ready.
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ADD_W-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

    logic [NREQ-1:0]  grant;
    logic [ID_W-1:0]  grant_id;
    logic             free, xfer;
    logic             mask_en, use_carry, carry_val;
    logic [ID_W-1:0]  mask_id;
    logic [ADD_W-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout;

`ifdef ADDER_ARB_LOCK_EN
    lock_state_e     state_q, state_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;
    logic            carry_q, carry_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= UNLOCKED;
            lock_id_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            carry_q   <= carry_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        carry_d   = carry_q;
        if (xfer) begin
            carry_d = add_cout;
            case (state_q)
                UNLOCKED: if (!req_last[grant_id]) begin
                    state_d   = LOCKED;
                    lock_id_d = grant_id;
                end
                LOCKED:   if (req_last[grant_id]) begin
                    state_d = UNLOCKED;
                end
                default:  state_d = UNLOCKED;
            endcase
        end
    end

    always_comb begin
        mask_en   = (state_q == LOCKED);
        use_carry = (state_q == LOCKED);
        mask_id   = lock_id_q;
        carry_val = carry_q;
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;

    always_comb begin
        mask_en   = 1'b0;
        use_carry = 1'b0;
        mask_id   = '0;
        carry_val = 1'b0;
    end
`endif

    rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
        .valid    (req_valid),
        .ptr      (ptr_q),
        .mask_en  (mask_en),
        .mask_id  (mask_id),
        .grant    (grant),
        .grant_id (grant_id)
    );

    adder_64 u_add (
        .in1  (add_a),
        .in2  (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        free      = !rsp_valid_q || rsp_ready;
        req_ready = (free && rst_n) ? grant : '0;
        xfer      = |(req_valid & req_ready);
        add_a     = req_in1[grant_id*ADD_W +: ADD_W];
        add_b     = req_in2[grant_id*ADD_W +: ADD_W];
        add_cin   = use_carry ? carry_val : req_cin[grant_id];
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = add_sum;
            rsp_cout_d  = add_cout;
            rsp_id_d    = grant_id;
            ptr_d       = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;

endmodule
